oven_timer_ctrl: RTL and testbench

- Cook-time sequencer for the microwave oven control FSM.
- Holds a programmed cook time in seconds and issues a 1-cycle `start` pulse to the oven FSM.
- Counts seconds down only while the oven reports `heat`, freezes while the door is open, and issues a 1-cycle `finish` pulse at zero. That pulse drives the oven FSM into its bell state.
- Sits between the front-panel keys and the oven FSM's start/finish inputs.

---
 rtl/oven_timer_if.sv | 28 ++
 rtl/oven_timer_ctrl.sv | 110 +++++++++++
 tb/tb_oven_timer_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/oven_timer_if.sv
// oven_timer_if: front-panel keys, oven FSM status and timer outputs of the cook-time sequencer.
interface oven_timer_if #(
    parameter int TIME_W = 12
);
    logic              door;
    logic              heat;
    logic              key_start;
    logic              key_cancel;
    logic              key_add;
    logic              time_load;
    logic [TIME_W-1:0] time_in;
    logic              start;
    logic              finish;
    logic [TIME_W-1:0] remaining;
    logic              tick_sec;
    logic              busy;
    logic              done;

    modport master (
        output door, heat, key_start, key_cancel, key_add, time_load, time_in,
        input  start, finish, remaining, tick_sec, busy, done
    );

    modport slave (
        input  door, heat, key_start, key_cancel, key_add, time_load, time_in,
        output start, finish, remaining, tick_sec, busy, done
    );
endinterface

// File: rtl/oven_timer_ctrl.sv
// oven_timer_ctrl: cook-time sequencer issuing start/finish pulses to the oven FSM.
module oven_timer_ctrl #(
    parameter int CLK_HZ  = 1000,
    parameter int TIME_W  = 12,
    parameter int ADD_SEC = 30
) (
    input  logic         clk,
    input  logic         rst,
    oven_timer_if.slave  bus
);
    localparam int PW = $clog2(CLK_HZ);
    localparam logic [TIME_W-1:0] MAX = '1;

    typedef enum logic [2:0] {IDLE, ARMED, RUN, HOLD, DONE} state_t;

    state_t            state, state_n;
    logic [TIME_W-1:0] rem, rem_n, base, add_sat;
    logic [PW-1:0]     pre, pre_n;
    logic [31:0]       sum;
    logic              tick, start_n, finish_n;

    // a tick is only possible in RUN when neither the door nor cancel takes precedence
    assign tick    = state == RUN && !bus.door && !bus.key_cancel && bus.heat && pre == PW'(CLK_HZ - 1);
    assign base    = tick ? rem - 1'b1 : rem;
    assign sum     = 32'(base) + 32'(ADD_SEC);
    assign add_sat = sum > 32'(MAX) ? MAX : sum[TIME_W-1:0];
    assign bus.remaining = rem;

    always_comb begin
        state_n  = state;
        rem_n    = rem;
        pre_n    = pre;
        start_n  = 1'b0;
        finish_n = 1'b0;
        case (state)
            IDLE: begin
                if (bus.time_load) begin
                    if (bus.time_in != '0) begin
                        rem_n   = bus.time_in;
                        state_n = ARMED;
                    end
                end else if (bus.key_add) begin
                    rem_n   = add_sat;
                    state_n = ARMED;
                end
            end
            ARMED: begin
                if (bus.key_cancel) begin
                    rem_n   = '0;
                    state_n = IDLE;
                end else if (bus.time_load) begin
                    rem_n   = bus.time_in;
                    state_n = bus.time_in == '0 ? IDLE : ARMED;
                end else if (bus.key_add) begin
                    rem_n = add_sat;
                end else if (bus.key_start && !bus.door) begin
                    start_n = 1'b1;
                    pre_n   = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (bus.door) begin
                    state_n = HOLD;
                end else if (bus.key_cancel) begin
                    finish_n = 1'b1;
                    rem_n    = '0;
                    state_n  = IDLE;
                end else begin
                    if (bus.heat) pre_n = tick ? '0 : pre + 1'b1;
                    // an add coinciding with the final tick keeps the oven cooking
                    if (bus.key_add) begin
                        rem_n = add_sat;
                    end else if (tick) begin
                        rem_n = base;
                        if (base == '0) begin
                            finish_n = 1'b1;
                            state_n  = DONE;
                        end
                    end
                end
            end
            HOLD:    state_n = bus.door ? HOLD : RUN;
            DONE:    state_n = bus.door ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rem          <= '0;
            pre          <= '0;
            bus.start    <= 1'b0;
            bus.finish   <= 1'b0;
            bus.tick_sec <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            state        <= state_n;
            rem          <= rem_n;
            pre          <= pre_n;
            bus.start    <= start_n;
            bus.finish   <= finish_n;
            bus.tick_sec <= tick;
            bus.busy     <= state_n == RUN || state_n == HOLD;
            bus.done     <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_oven_timer_ctrl.sv
// tb_oven_timer_ctrl: directed steps with a per-cycle expected-output scoreboard plus targeted checks.
module tb_oven_timer_ctrl;
    localparam int CLK_HZ  = 4;
    localparam int TIME_W  = 4;
    localparam int ADD_SEC = 30;

    typedef struct {
        string      tag;
        logic [8:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_start = 0, n_finish = 0, n_tick = 0;
    int   m_st = 0, m_rem = 0, m_pre = 0;

    oven_timer_if #(.TIME_W(TIME_W)) bus ();

    oven_timer_ctrl #(.CLK_HZ(CLK_HZ), .TIME_W(TIME_W), .ADD_SEC(ADD_SEC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int x);
        return x > 15 ? 15 : x;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic settle();
        exp_t       e;
        logic [8:0] obs;
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        obs = {bus.start, bus.finish, bus.tick_sec, bus.busy, bus.done, bus.remaining};
        checks++;
        assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
        end
        n_start  += int'(bus.start);
        n_finish += int'(bus.finish);
        n_tick   += int'(bus.tick_sec);
    endtask

    task automatic do_reset(input string tag);
        exp_t e;
        rst = 1'b1;
        {bus.door, bus.heat, bus.key_start, bus.key_cancel, bus.key_add, bus.time_load} = '0;
        bus.time_in = '0;
        m_st = 0; m_rem = 0; m_pre = 0;
        e.tag = tag;
        e.v   = '0;
        sb.push_back(e);
        settle();
        rst = 1'b0;
    endtask

    // states: 0 IDLE, 1 ARMED, 2 RUN, 3 HOLD, 4 DONE
    task automatic step(input string tag, input logic d, input logic h, input logic ks,
                        input logic kc, input logic ka, input logic tl, input int ti);
        exp_t e;
        int   nst = m_st, nrem = m_rem, npre = m_pre, base;
        logic es = 0, ef = 0, et = 0;
        bus.door = d; bus.heat = h; bus.key_start = ks; bus.key_cancel = kc;
        bus.key_add = ka; bus.time_load = tl; bus.time_in = 4'(ti);
        case (m_st)
            0: if (tl) begin
                   if (ti != 0) begin nrem = ti; nst = 1; end
               end else if (ka) begin nrem = sat(m_rem + ADD_SEC); nst = 1; end
            1: if (kc) begin nrem = 0; nst = 0; end
               else if (tl) begin nrem = ti; if (ti == 0) nst = 0; end
               else if (ka) nrem = sat(m_rem + ADD_SEC);
               else if (ks && !d) begin es = 1; npre = 0; nst = 2; end
            2: if (d) nst = 3;
               else if (kc) begin ef = 1; nrem = 0; nst = 0; end
               else begin
                   if (h) begin npre = (m_pre + 1) % CLK_HZ; et = (npre == 0); end
                   base = m_rem - (et ? 1 : 0);
                   if (ka) nrem = sat(base + ADD_SEC);
                   else if (et) begin
                       nrem = base;
                       if (base == 0) begin ef = 1; nst = 4; end
                   end
               end
            3: if (!d) nst = 2;
            default: if (d) nst = 0;
        endcase
        m_st = nst; m_rem = nrem; m_pre = npre;
        e.tag = tag;
        e.v   = {es, ef, et, (nst == 2 || nst == 3) ? 1'b1 : 1'b0, nst == 4 ? 1'b1 : 1'b0, 4'(nrem)};
        sb.push_back(e);
        settle();
    endtask

    initial begin
        do_reset("reset0");
        do_reset("reset1");
        chk("rst_remaining", int'(bus.remaining), 0);
        chk("rst_busy", int'(bus.busy), 0);

        // full cook of 3 seconds
        n_start = 0; n_finish = 0; n_tick = 0;
        step("t1_load3", 0, 0, 0, 0, 0, 1, 3);
        step("t1_start", 0, 0, 1, 0, 0, 0, 0);
        chk("t1_start_pulse", int'(bus.start), 1);
        repeat (12) step("t1_heat", 0, 1, 0, 0, 0, 0, 0);
        chk("t1_start_count", n_start, 1);
        chk("t1_tick_count", n_tick, 3);
        chk("t1_finish_count", n_finish, 1);
        chk("t1_done", int'(bus.done), 1);
        chk("t1_remaining", int'(bus.remaining), 0);
        step("t1_door_open", 1, 0, 0, 0, 0, 0, 0);
        chk("t1_done_cleared", int'(bus.done), 0);

        // door open pauses the countdown, prescaler retained
        step("t2_load2", 0, 0, 0, 0, 0, 1, 2);
        step("t2_start", 0, 0, 1, 0, 0, 0, 0);
        repeat (2) step("t2_heat", 0, 1, 0, 0, 0, 0, 0);
        n_tick = 0;
        repeat (5) step("t2_hold", 1, 0, 0, 0, 0, 0, 0);
        step("t2_hold_cancel", 1, 0, 0, 1, 0, 0, 0);
        repeat (4) step("t2_hold", 1, 0, 0, 0, 0, 0, 0);
        chk("t2_hold_remaining", int'(bus.remaining), 2);
        chk("t2_hold_busy", int'(bus.busy), 1);
        chk("t2_hold_ticks", n_tick, 0);
        step("t2_close", 0, 0, 0, 0, 0, 0, 0);
        step("t2_heat3", 0, 1, 0, 0, 0, 0, 0);
        chk("t2_no_tick_yet", n_tick, 0);
        step("t2_heat4", 0, 1, 0, 0, 0, 0, 0);
        chk("t2_first_tick", n_tick, 1);
        chk("t2_remaining1", int'(bus.remaining), 1);
        step("t2_cancel", 0, 0, 0, 1, 0, 0, 0);

        // saturating add
        step("t3_add_idle", 0, 0, 0, 0, 1, 0, 0);
        chk("t3_add_sat", int'(bus.remaining), 15);
        step("t3_cancel", 0, 0, 0, 1, 0, 0, 0);
        step("t3_load14", 0, 0, 0, 0, 0, 1, 14);
        step("t3_add14", 0, 0, 0, 0, 1, 0, 0);
        chk("t3_add14_sat", int'(bus.remaining), 15);
        step("t3_load1", 0, 0, 0, 0, 0, 1, 1);
        step("t3_start", 0, 0, 1, 0, 0, 0, 0);
        repeat (3) step("t3_heat", 0, 1, 0, 0, 0, 0, 0);
        n_finish = 0;
        step("t3_tick_add", 0, 1, 0, 0, 1, 0, 0);
        chk("t3_tick_add_rem", int'(bus.remaining), 15);
        chk("t3_no_finish", n_finish, 0);
        chk("t3_still_busy", int'(bus.busy), 1);
        step("t3_cancel_run", 0, 0, 0, 1, 0, 0, 0);

        // cancel in RUN
        step("t4_load5", 0, 0, 0, 0, 0, 1, 5);
        step("t4_start", 0, 0, 1, 0, 0, 0, 0);
        repeat (2) step("t4_heat", 0, 1, 0, 0, 0, 0, 0);
        step("t4_cancel", 0, 1, 0, 1, 0, 0, 0);
        chk("t4_finish", int'(bus.finish), 1);
        chk("t4_remaining", int'(bus.remaining), 0);
        chk("t4_busy", int'(bus.busy), 0);
        step("t4_after", 0, 0, 0, 0, 0, 0, 0);
        chk("t4_finish_once", int'(bus.finish), 0);

        // ignored inputs
        step("t5_load2", 0, 0, 0, 0, 0, 1, 2);
        step("t5_start_door", 1, 0, 1, 0, 0, 0, 0);
        chk("t5_no_start", int'(bus.start), 0);
        chk("t5_not_busy", int'(bus.busy), 0);
        step("t5_load0_armed", 0, 0, 0, 0, 0, 1, 0);
        chk("t5_load0_rem", int'(bus.remaining), 0);
        step("t5_load0_idle", 0, 0, 0, 0, 0, 1, 0);
        step("t5_start_idle", 0, 0, 1, 0, 0, 0, 0);
        chk("t5_idle_no_start", int'(bus.start), 0);
        step("t5_load0_add", 0, 0, 0, 0, 1, 1, 0);
        chk("t5_load_wins", int'(bus.remaining), 0);

        // reset mid-run, then finish and open the door
        step("t6_load7", 0, 0, 0, 0, 0, 1, 7);
        step("t6_start", 0, 0, 1, 0, 0, 0, 0);
        step("t6_heat", 0, 1, 0, 0, 0, 0, 0);
        chk("t6_rem7", int'(bus.remaining), 7);
        do_reset("t6_reset");
        chk("t6_rst_rem", int'(bus.remaining), 0);
        chk("t6_rst_finish", int'(bus.finish), 0);
        chk("t6_rst_busy", int'(bus.busy), 0);
        step("t6_idle", 0, 1, 0, 0, 0, 0, 0);
        step("t6_load1", 0, 0, 0, 0, 0, 1, 1);
        step("t6_start2", 0, 0, 1, 0, 0, 0, 0);
        repeat (4) step("t6_heat", 0, 1, 0, 0, 0, 0, 0);
        chk("t6_done", int'(bus.done), 1);
        step("t6_door", 1, 0, 0, 0, 0, 0, 0);
        chk("t6_idle_after_door", int'(bus.done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
